aurora_tx_sched: RTL and testbench

AURORA_TX_SCHED -- requirements
Module: aurora_tx_sched

---
 rtl/aurora_pkg.sv | 37 +++
 rtl/aurora_tx_sched_if.sv | 53 +++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/aurora_tx_sched.sv | 139 +++++++++++++
 tb/tb_aurora_tx_sched.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aurora_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aurora_pkg
// Description : Shared constants, state encoding and header builder for the
//               Aurora TX burst scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package aurora_pkg;

    // Header word layout: {nibble, source index, burst length}
    localparam int c_HDR_NIB_W = 4;
    localparam int c_HDR_SRC_W = 4;
    localparam int c_HDR_LEN_W = 8;
    localparam int c_HDR_W     = c_HDR_NIB_W + c_HDR_SRC_W + c_HDR_LEN_W;

    localparam logic [c_HDR_NIB_W-1:0] c_HDR_NIBBLE = 4'hA;

    // Width of the completed-burst counter
    localparam int c_CNT_W = 16;

    // Scheduler states with fixed encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HDR  = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    // Assemble the 16-bit burst header word
    function automatic logic [c_HDR_W-1:0] f_build_hdr(
        input logic [c_HDR_SRC_W-1:0] src,
        input logic [c_HDR_LEN_W-1:0] len
    );
        return {c_HDR_NIBBLE, src, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aurora_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : aurora_tx_sched_if
// Description : Requester-side and Aurora-side signal bundle for the TX
//               scheduler. master = scheduler, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface aurora_tx_sched_if
    import aurora_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_REQ      = 4
);

    logic                        CHANNEL_UP;
    logic [N_REQ*DATA_WIDTH-1:0] REQ_D;
    logic [N_REQ-1:0]            REQ_SRC_RDY_N;
    logic [N_REQ-1:0]            REQ_BURST_RDY;
    logic [N_REQ-1:0]            REQ_DST_RDY_N;
    logic [DATA_WIDTH-1:0]       TX_D;
    logic                        TX_SRC_RDY_N;
    logic                        TX_DST_RDY_N;
    logic [N_REQ-1:0]            GRANT;
    logic [c_CNT_W-1:0]          BURST_COUNT;

    modport master (
        input  CHANNEL_UP,
        input  REQ_D,
        input  REQ_SRC_RDY_N,
        input  REQ_BURST_RDY,
        input  TX_DST_RDY_N,
        output REQ_DST_RDY_N,
        output TX_D,
        output TX_SRC_RDY_N,
        output GRANT,
        output BURST_COUNT
    );

    modport slave (
        output CHANNEL_UP,
        output REQ_D,
        output REQ_SRC_RDY_N,
        output REQ_BURST_RDY,
        output TX_DST_RDY_N,
        input  REQ_DST_RDY_N,
        input  TX_D,
        input  TX_SRC_RDY_N,
        input  GRANT,
        input  BURST_COUNT
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches upward from
//               (last grant + 1) with wrap; emits one-hot grant, its index
//               and a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0] i_last,
    output logic      [N_REQ-1:0] o_grant,
    output logic      [IDX_W-1:0] o_grant_idx,
    output logic                  o_valid
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // First requesting index after the last winner, wrapping modulo N_REQ
    always_comb begin
        w_cand      = '0;
        w_found     = 1'b0;
        o_grant     = '0;
        o_grant_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last) + k) % N_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
        o_valid = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/aurora_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : aurora_tx_sched
// Description : Aurora TX burst scheduler. Picks a requester round-robin,
//               sends a header word, then passes BURST_LEN data words
//               straight through from the owner to the Aurora TX port.
// Revision    : 1.0 - initial release
// ============================================================================
module aurora_tx_sched
    import aurora_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_REQ      = 4,
    parameter int BURST_LEN  = 16
) (
    input wire logic          USER_CLK,
    input wire logic          RESET,
    aurora_tx_sched_if.master bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [c_HDR_LEN_W-1:0] c_BURST_LEN      = c_HDR_LEN_W'(BURST_LEN);
    localparam logic [c_HDR_LEN_W-1:0] c_LAST_WORD      = c_HDR_LEN_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]       c_LAST_GRANT_RST = IDX_W'(N_REQ - 1);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [IDX_W-1:0]       r_last_grant;
    logic [N_REQ-1:0]       r_grant_oh;
    logic [c_HDR_LEN_W-1:0] r_word_cnt;
    logic [c_CNT_W-1:0]     r_burst_count;

    logic [N_REQ-1:0]       w_arb_grant;
    logic [IDX_W-1:0]       w_arb_idx;
    logic                   w_arb_valid;
    logic [DATA_WIDTH-1:0]  w_req_words [N_REQ];
    logic [DATA_WIDTH-1:0]  w_hdr;
    logic [DATA_WIDTH-1:0]  w_tx_d;
    logic                   w_tx_src_rdy_n;
    logic [N_REQ-1:0]       w_req_dst_rdy_n;
    logic                   w_xfer;

    // Split the flat requester data bus into one word per requester
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_req_words[gi] = bus.REQ_D[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req       (bus.REQ_BURST_RDY),
        .i_last      (r_last_grant),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx),
        .o_valid     (w_arb_valid)
    );

    // Header carries the owner index, zero-padded above 16 bits
    assign w_hdr = DATA_WIDTH'(f_build_hdr(c_HDR_SRC_W'(r_grant_idx), c_BURST_LEN));

    // Zero-latency datapath and handshakes; a dead channel masks every handshake
    always_comb begin
        w_tx_d          = '0;
        w_tx_src_rdy_n  = 1'b1;
        w_req_dst_rdy_n = '1;
        case (r_state)
            ST_HDR: begin
                w_tx_d         = w_hdr;
                w_tx_src_rdy_n = ~bus.CHANNEL_UP;
            end
            ST_DATA: begin
                w_tx_d                       = w_req_words[r_grant_idx];
                w_tx_src_rdy_n               = bus.REQ_SRC_RDY_N[r_grant_idx] | ~bus.CHANNEL_UP;
                w_req_dst_rdy_n[r_grant_idx] = bus.TX_DST_RDY_N | w_tx_src_rdy_n;
            end
            default: ;
        endcase
    end

    // A word moves only when both sides of the Aurora handshake are ready
    assign w_xfer = ~w_tx_src_rdy_n & ~bus.TX_DST_RDY_N;

    // Scheduler FSM: arbitrate in IDLE, send header, then count data words
    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_grant_idx   <= '0;
            r_last_grant  <= c_LAST_GRANT_RST;
            r_grant_oh    <= '0;
            r_word_cnt    <= '0;
            r_burst_count <= '0;
        end else if (!bus.CHANNEL_UP) begin
            // Abort: drop ownership, keep last_grant so the victim keeps priority
            r_state    <= ST_IDLE;
            r_grant_oh <= '0;
            r_word_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant_idx <= w_arb_idx;
                        r_grant_oh  <= w_arb_grant;
                        r_state     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_xfer) begin
                        r_word_cnt <= '0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        if (r_word_cnt == c_LAST_WORD) begin
                            r_burst_count <= r_burst_count + c_CNT_W'(1);
                            r_last_grant  <= r_grant_idx;
                            r_grant_oh    <= '0;
                            r_word_cnt    <= '0;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_word_cnt <= r_word_cnt + c_HDR_LEN_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.TX_D          = w_tx_d;
    assign bus.TX_SRC_RDY_N  = w_tx_src_rdy_n;
    assign bus.REQ_DST_RDY_N = w_req_dst_rdy_n;
    assign bus.GRANT         = r_grant_oh;
    assign bus.BURST_COUNT   = r_burst_count;

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aurora_tx_sched
// Description : Directed self-checking bench for aurora_tx_sched
//               (DATA_WIDTH=16, N_REQ=4, BURST_LEN=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aurora_tx_sched;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int BL = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    aurora_tx_sched_if #(.DATA_WIDTH(DW), .N_REQ(NR)) bus ();

    aurora_tx_sched #(
        .DATA_WIDTH (DW),
        .N_REQ      (NR),
        .BURST_LEN  (BL)
    ) dut (
        .USER_CLK (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    int              n_checks = 0;
    int              n_errors = 0;
    int              ptr [NR];
    logic [DW-1:0]   txlog [$];

    // Values captured mid-cycle by cyc()
    logic [DW-1:0]   o_txd;
    logic            o_src_n;
    logic [NR-1:0]   o_dst;
    logic [NR-1:0]   o_grant;
    logic [15:0]     o_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Requester r presents word k as {r+1, k}
    function automatic logic [DW-1:0] word_of(input int r, input int k);
        return {8'(r + 1), 8'(k)};
    endfunction

    // One clock: present requester words, capture outputs, log transfers,
    // advance each requester whose word was accepted
    task automatic cyc();
        for (int r = 0; r < NR; r++) bus.REQ_D[r*DW +: DW] = word_of(r, ptr[r]);
        #1;
        o_txd   = bus.TX_D;
        o_src_n = bus.TX_SRC_RDY_N;
        o_dst   = bus.REQ_DST_RDY_N;
        o_grant = bus.GRANT;
        o_cnt   = bus.BURST_COUNT;
        if (!bus.TX_SRC_RDY_N && !bus.TX_DST_RDY_N) txlog.push_back(bus.TX_D);
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) if (!o_dst[r]) ptr[r]++;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        bus.CHANNEL_UP    = 1'b0;
        bus.REQ_BURST_RDY = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int r = 0; r < NR; r++) ptr[r] = 0;
        txlog.delete();
    endtask

    initial begin
        bus.CHANNEL_UP    = 1'b0;
        bus.REQ_BURST_RDY = '0;
        bus.REQ_SRC_RDY_N = '1;
        bus.TX_DST_RDY_N  = 1'b1;
        bus.REQ_D         = '0;
        for (int r = 0; r < NR; r++) ptr[r] = 0;

        // ---- Reset values (asynchronous assertion, before any clock edge)
        #1 rst = 1'b1;
        #1;
        chk("rst_tx_src_rdy_n", bus.TX_SRC_RDY_N, 1);
        chk("rst_req_dst_rdy_n", bus.REQ_DST_RDY_N, 4'hF);
        chk("rst_grant", bus.GRANT, 0);
        chk("rst_tx_d", bus.TX_D, 0);
        chk("rst_burst_count", bus.BURST_COUNT, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- Single burst from requester 0, continuous flow
        bus.CHANNEL_UP    = 1'b1;
        bus.TX_DST_RDY_N  = 1'b0;
        bus.REQ_SRC_RDY_N = 4'b0000;
        bus.REQ_BURST_RDY = 4'b0001;
        cyc();
        chk("t1_first_cycle_grant", o_grant, 0);
        chk("t1_first_cycle_src", o_src_n, 1);
        bus.REQ_BURST_RDY = 4'b0000;
        for (int i = 0; i < 17; i++) begin
            cyc();
            chk("t1_grant", o_grant, 4'b0001);
        end
        cyc();
        chk("t1_grant_after", o_grant, 0);
        chk("t1_idle_txd", o_txd, 0);
        chk("t1_burst_count", o_cnt, 1);
        chk("t1_xfer_count", txlog.size(), 17);
        chk("t1_header", txlog[0], 16'hA010);
        for (int k = 1; k < txlog.size(); k++) chk("t1_data", txlog[k], 16'h0100 + 16'(k - 1));

        // ---- All requesters ready: round-robin header order
        do_reset();
        bus.CHANNEL_UP    = 1'b1;
        bus.TX_DST_RDY_N  = 1'b0;
        bus.REQ_SRC_RDY_N = 4'b0000;
        bus.REQ_BURST_RDY = 4'b1111;
        repeat (90) cyc();
        bus.REQ_BURST_RDY = 4'b0000;
        chk("t2_burst_count", bus.BURST_COUNT, 5);
        chk("t2_xfer_count", txlog.size(), 85);
        chk("t2_hdr0", txlog[0], 16'hA010);
        chk("t2_hdr1", txlog[17], 16'hA110);
        chk("t2_hdr2", txlog[34], 16'hA210);
        chk("t2_hdr3", txlog[51], 16'hA310);
        chk("t2_hdr4", txlog[68], 16'hA010);
        chk("t2_req1_first", txlog[18], 16'h0200);
        chk("t2_req0_second_burst", txlog[69], 16'h0110);
        chk("t2_req0_second_last", txlog[84], 16'h011F);

        // ---- Aurora back-pressure every other cycle
        do_reset();
        bus.CHANNEL_UP    = 1'b1;
        bus.REQ_SRC_RDY_N = 4'b0000;
        bus.REQ_BURST_RDY = 4'b0001;
        begin
            logic hdr_seen;
            logic dn;
            hdr_seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                dn = logic'(i % 2);
                bus.TX_DST_RDY_N = dn;
                cyc();
                if (i == 0) bus.REQ_BURST_RDY = 4'b0000;
                if (hdr_seen && o_grant == 4'b0001) chk("t3_dst_mirror", o_dst, {3'b111, dn});
                if (txlog.size() >= 1) hdr_seen = 1'b1;
            end
        end
        chk("t3_xfer_count", txlog.size(), 17);
        chk("t3_header", txlog[0], 16'hA010);
        for (int k = 1; k < txlog.size(); k++) chk("t3_data", txlog[k], 16'h0100 + 16'(k - 1));
        chk("t3_burst_count", bus.BURST_COUNT, 1);

        // ---- Requester 2 stalls for 5 cycles after word 7
        do_reset();
        bus.CHANNEL_UP    = 1'b1;
        bus.TX_DST_RDY_N  = 1'b0;
        bus.REQ_SRC_RDY_N = 4'b0000;
        bus.REQ_BURST_RDY = 4'b0100;
        begin
            int   stall;
            logic stalling;
            stall = 0;
            for (int i = 0; i < 30; i++) begin
                stalling = (ptr[2] == 8) && (stall < 5);
                bus.REQ_SRC_RDY_N = stalling ? 4'b0100 : 4'b0000;
                cyc();
                if (i == 0) bus.REQ_BURST_RDY = 4'b0000;
                if (stalling) begin
                    chk("t4_stall_src", o_src_n, 1);
                    chk("t4_stall_dst", o_dst, 4'hF);
                    chk("t4_stall_grant", o_grant, 4'b0100);
                    chk("t4_stall_count", o_cnt, 0);
                    stall++;
                end
            end
        end
        bus.REQ_SRC_RDY_N = 4'b0000;
        chk("t4_xfer_count", txlog.size(), 17);
        chk("t4_header", txlog[0], 16'hA210);
        for (int k = 1; k < txlog.size(); k++) chk("t4_data", txlog[k], 16'h0300 + 16'(k - 1));
        chk("t4_burst_count", bus.BURST_COUNT, 1);

        // ---- Channel drop mid-burst of requester 1, then regrant
        do_reset();
        bus.CHANNEL_UP    = 1'b1;
        bus.TX_DST_RDY_N  = 1'b0;
        bus.REQ_SRC_RDY_N = 4'b0000;
        bus.REQ_BURST_RDY = 4'b0001;
        cyc();
        bus.REQ_BURST_RDY = 4'b0000;
        repeat (18) cyc();
        chk("t5_count_before", bus.BURST_COUNT, 1);
        bus.REQ_BURST_RDY = 4'b0010;
        cyc();
        bus.REQ_BURST_RDY = 4'b0000;
        for (int i = 0; i < 40 && ptr[1] < 11; i++) cyc();
        chk("t5_words_accepted", ptr[1], 11);
        bus.CHANNEL_UP = 1'b0;
        cyc();
        chk("t5_drop_src", o_src_n, 1);
        chk("t5_drop_dst", o_dst, 4'hF);
        cyc();
        chk("t5_idle_grant", o_grant, 0);
        chk("t5_idle_txd", o_txd, 0);
        chk("t5_idle_count", o_cnt, 1);
        bus.CHANNEL_UP    = 1'b1;
        bus.REQ_BURST_RDY = 4'b0011;
        txlog.delete();
        cyc();
        cyc();
        chk("t5_regrant_hdr", o_txd, 16'hA110);
        chk("t5_regrant_grant", o_grant, 4'b0010);
        bus.REQ_BURST_RDY = 4'b0000;

        // ---- Asynchronous reset in the middle of DATA
        repeat (3) cyc();
        chk("t6_in_data_grant", bus.GRANT, 4'b0010);
        chk("t6_count_before", bus.BURST_COUNT, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_src", bus.TX_SRC_RDY_N, 1);
        chk("t6_rst_dst", bus.REQ_DST_RDY_N, 4'hF);
        chk("t6_rst_grant", bus.GRANT, 0);
        chk("t6_rst_txd", bus.TX_D, 0);
        chk("t6_rst_count", bus.BURST_COUNT, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
